// File: rtl/rca32_tt3_adder.sv
// 32-bit approximate ripple-carry adder with a registered 33-bit result.
// The low APPROX_BITS positions add without carries; the rest form an exact full-adder chain.

module rca32_tt3_fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic p;

    assign p    = a ^ b;
    assign s    = p ^ cin;
    assign cout = (a & b) | (cin & p);
endmodule

module rca32_tt3_approx_cell (
    input  logic a,
    input  logic b,
    output logic s
);
    assign s = a ^ b;
endmodule

module rca32_tt3_adder #(
    parameter int unsigned APPROX_BITS = 3
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        in_valid,
    input  logic [31:0] data_a,
    input  logic [31:0] data_b,
    output logic [32:0] sum_o,
    output logic        out_valid
);
    localparam int unsigned AB = APPROX_BITS;

    logic [31:0] sum_bits;
    logic [32:AB] carry;

    generate
        if (AB > 8) begin : g_bad_cfg
            $error("rca32_tt3_adder: APPROX_BITS=%0d exceeds the legal range 0..8", AB);
        end

        // The approximate region never propagates a carry; only its top pair seeds the exact chain.
        if (AB == 0) begin : g_no_approx
            assign carry[0] = 1'b0;
        end else begin : g_approx
            for (genvar i = 0; i < int'(AB); i++) begin : g_cell
                rca32_tt3_approx_cell u_cell (
                    .a (data_a[i]),
                    .b (data_b[i]),
                    .s (sum_bits[i])
                );
            end
            assign carry[AB] = data_a[AB-1] & data_b[AB-1];
        end

        for (genvar i = int'(AB); i < 32; i++) begin : g_exact
            rca32_tt3_fa u_fa (
                .a    (data_a[i]),
                .b    (data_b[i]),
                .cin  (carry[i]),
                .s    (sum_bits[i]),
                .cout (carry[i+1])
            );
        end
    endgenerate

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sum_o     <= 33'h0;
            out_valid <= 1'b0;
        end else begin
            sum_o     <= {carry[32], sum_bits};
            out_valid <= in_valid;
        end
    end
endmodule

// File: tb/tb_rca32_tt3_adder.sv
// Self-checking bench: two adder configurations (3 approximate bits and exact) share one stimulus stream.
`timescale 1ns/1ps

module tb_rca32_tt3_adder;
    logic        Clk;
    logic        Rst_n;
    logic        in_valid;
    logic [31:0] data_a;
    logic [31:0] data_b;
    logic [32:0] sum3;
    logic [32:0] sum0;
    logic        valid3;
    logic        valid0;

    int errors = 0;
    int checks = 0;

    rca32_tt3_adder #(.APPROX_BITS(3)) dut3 (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .in_valid  (in_valid),
        .data_a    (data_a),
        .data_b    (data_b),
        .sum_o     (sum3),
        .out_valid (valid3)
    );

    rca32_tt3_adder #(.APPROX_BITS(0)) dut0 (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .in_valid  (in_valid),
        .data_a    (data_a),
        .data_b    (data_b),
        .sum_o     (sum0),
        .out_valid (valid0)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference: XOR in the low ab bits, ordinary addition of the shifted upper parts plus the seed carry.
    function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b, input int ab);
        logic [32:0] mask;
        logic [32:0] upper;
        logic [32:0] low;
        logic [32:0] c;
        if (ab == 0) return {1'b0, a} + {1'b0, b};
        mask  = (33'h1 << ab) - 33'h1;
        low   = {1'b0, a ^ b} & mask;
        c     = ({1'b0, a} >> (ab - 1)) & ({1'b0, b} >> (ab - 1)) & 33'h1;
        upper = ({1'b0, a} >> ab) + ({1'b0, b} >> ab) + c;
        return (upper << ab) | low;
    endfunction

    task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic [31:0] a, input logic [31:0] b, input logic v);
        @(negedge Clk);
        data_a   = a;
        data_b   = b;
        in_valid = v;
        @(posedge Clk);
        #1;
    endtask

    logic [31:0] ra, rb;
    logic        rv;

    initial begin
        Rst_n    = 1'b0;
        in_valid = 1'b1;
        data_a   = 32'hDEAD_BEEF;
        data_b   = 32'h1234_5678;
        #3;
        check("reset_sum3", sum3, 33'h0);
        check("reset_valid3", {32'h0, valid3}, 33'h0);
        @(posedge Clk); #1;
        check("reset_hold_sum3", sum3, 33'h0);
        check("reset_hold_valid0", {32'h0, valid0}, 33'h0);
        @(negedge Clk);
        Rst_n = 1'b1;

        cycle(32'd5, 32'd3, 1'b1);
        check("approx_5p3", sum3, 33'd6);
        check("approx_5p3_valid", {32'h0, valid3}, 33'h1);
        check("exact_5p3", sum0, 33'd8);

        cycle(32'd7, 32'd7, 1'b1);
        check("approx_7p7", sum3, 33'd8);
        check("exact_7p7", sum0, 33'd14);

        cycle(32'hFFFF_FFFF, 32'd1, 1'b1);
        check("approx_ffp1", sum3, 33'h0_FFFF_FFFE);
        check("exact_ffp1", sum0, 33'h1_0000_0000);

        cycle(32'h100, 32'h200, 1'b1);
        check("upper_100p200", sum3, 33'h300);

        cycle(32'hFFFF_FFF8, 32'd8, 1'b1);
        check("carry_out_approx", sum3, 33'h1_0000_0000);
        check("carry_out_exact", sum0, 33'h1_0000_0000);

        // Asynchronous reset mid-cycle with a nonzero result registered.
        #2;
        Rst_n = 1'b0;
        #1;
        check("async_rst_sum3", sum3, 33'h0);
        check("async_rst_sum0", sum0, 33'h0);
        check("async_rst_valid3", {32'h0, valid3}, 33'h0);
        data_a   = 32'h100;
        data_b   = 32'h200;
        in_valid = 1'b1;
        @(posedge Clk); #1;
        check("rst_hold_sum3", sum3, 33'h0);
        check("rst_hold_valid3", {32'h0, valid3}, 33'h0);
        @(negedge Clk);
        Rst_n = 1'b1;
        @(posedge Clk); #1;
        check("release_sum3", sum3, 33'h300);
        check("release_valid3", {32'h0, valid3}, 33'h1);

        // Alternating valid with changing operands.
        cycle(32'h0000_1111, 32'h0000_2222, 1'b1);
        check("alt1_sum3", sum3, model(32'h0000_1111, 32'h0000_2222, 3));
        check("alt1_valid", {32'h0, valid3}, 33'h1);
        cycle(32'h8000_0000, 32'h8000_0001, 1'b0);
        check("alt0_sum3", sum3, model(32'h8000_0000, 32'h8000_0001, 3));
        check("alt0_sum0", sum0, 33'h1_0000_0001);
        check("alt0_valid", {32'h0, valid0}, 33'h0);
        cycle(32'h0000_000F, 32'h0000_000C, 1'b1);
        check("alt1b_sum3", sum3, model(32'h0000_000F, 32'h0000_000C, 3));
        check("alt1b_valid", {32'h0, valid3}, 33'h1);

        // Random stream, one operand pair per cycle.
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 7 == 0) rb = ~ra;
            rv = 1'($urandom_range(0, 1));
            cycle(ra, rb, rv);
            check("rand_exact", sum0, {1'b0, ra} + {1'b0, rb});
            check("rand_approx", sum3, model(ra, rb, 3));
            check("rand_valid", {31'h0, valid3, valid0}, {31'h0, rv, rv});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
